// File: rtl/counter_pkg.sv
// Shared definitions for the counter controller: FSM state encoding and default width.
package counter_pkg;

    localparam int CNT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } cnt_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer advances only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // r_prio names the requester that wins a tie (0 after reset)
    logic r_prio;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (accept && (gnt != 2'b00)) begin
            r_prio <= gnt[0];
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Arbitrated counter job controller: IDLE -> LOAD -> RUN (N cycles) -> DONE.
// Optional job cancel input is built when CNT_CTRL_ABORT_EN is defined.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] load_val_0,
    input  logic [WIDTH-1:0] load_val_1,
    input  logic [WIDTH-1:0] run_len_0,
    input  logic [WIDTH-1:0] run_len_1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en
`ifdef CNT_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    cnt_state_t       r_state;
    cnt_state_t       w_state_next;
    logic [1:0]       r_gnt;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_remain;
    logic [1:0]       w_arb_gnt;
    logic             w_accept;
    logic             w_abort;
    logic [WIDTH-1:0] w_sel_load;
    logic [WIDTH-1:0] w_sel_len;

`ifdef CNT_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (w_accept),
        .gnt    (w_arb_gnt)
    );

    assign w_sel_load = w_arb_gnt[1] ? load_val_1 : load_val_0;
    assign w_sel_len  = w_arb_gnt[1] ? run_len_1  : run_len_0;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_state_next = ST_LOAD;
                    w_accept     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_abort || (r_remain == '0)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // r_remain counts the RUN cycles still owed, including this one
                if (w_abort || (r_remain <= WIDTH'(1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 2'b00;
            r_load_val <= '0;
            r_remain   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_gnt      <= w_arb_gnt;
                r_load_val <= w_sel_load;
                r_remain   <= w_sel_len;
            end else if ((r_state == ST_RUN) && (r_remain != '0)) begin
                r_remain <= r_remain - WIDTH'(1);
            end
            if (r_state == ST_DONE) begin
                r_gnt <= 2'b00;
            end
        end
    end

    assign gnt          = r_gnt;
    assign done         = (r_state == ST_DONE) ? r_gnt : 2'b00;
    assign busy         = (r_state != ST_IDLE);
    assign cnt_load     = (r_state == ST_LOAD);
    assign cnt_load_val = r_load_val;
    assign cnt_en       = (r_state == ST_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl; abort scenario is built when CNT_CTRL_ABORT_EN is defined.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] load_val_0 = 8'h00;
    logic [7:0] load_val_1 = 8'h00;
    logic [7:0] run_len_0 = 8'h00;
    logic [7:0] run_len_1 = 8'h00;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_en;
`ifdef CNT_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    counter_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .load_val_0   (load_val_0),
        .load_val_1   (load_val_1),
        .run_len_0    (run_len_0),
        .run_len_1    (run_len_1),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en)
`ifdef CNT_CTRL_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    always #5 clk = ~clk;

    // Observes one job from the current negedge until the IDLE cycle after it.
    task automatic run_job(input bit hold, output int idle_n, output int load_n,
                           output int en_n, output int busy_n, output int done_n,
                           output logic [1:0] done_v, output logic [1:0] gnt_v,
                           output logic [7:0] ldv_load, output logic [7:0] ldv_end,
                           output int both_n, output int gnt_bad, output bit timeout);
        bit seen = 0;
        idle_n = 0; load_n = 0; en_n = 0; busy_n = 0; done_n = 0; both_n = 0; gnt_bad = 0;
        done_v = 2'b00; gnt_v = 2'b00; ldv_load = 8'h00; ldv_end = 8'h00; timeout = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                if (seen) begin
                    timeout = 0;
                    break;
                end
                idle_n++;
            end else begin
                if (!seen) begin
                    seen = 1;
                    gnt_v = gnt;
                    if (!hold) begin
                        req = 2'b00;
                        load_val_0 = 8'h3C; load_val_1 = 8'h3C;
                        run_len_0 = 8'd7; run_len_1 = 8'd7;
                    end
                end
                busy_n++;
                if (cnt_load) begin load_n++; ldv_load = cnt_load_val; end
                if (cnt_en) en_n++;
                if (cnt_load && cnt_en) both_n++;
                if (gnt !== gnt_v) gnt_bad++;
                if (done !== 2'b00) begin done_n++; done_v = done; end
                ldv_end = cnt_load_val;
            end
        end
        $display("job: gnt=%b load_val=%h en_cycles=%0d busy_cycles=%0d done=%b done_pulses=%0d",
                 gnt_v, ldv_load, en_n, busy_n, done_v, done_n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt, done, busy, cnt_load, cnt_en, cnt_load_val} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b done=%b busy=%b load=%b en=%b val=%h required all zero",
                     gnt, done, busy, cnt_load, cnt_en, cnt_load_val);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int idle_n, load_n, en_n, busy_n, done_n, both_n, gnt_bad;
        logic [1:0] done_v, gnt_v;
        logic [7:0] ldv_load, ldv_end;
        bit to;
        req = 2'b01; load_val_0 = 8'hC5; run_len_0 = 8'd3;
        run_job(0, idle_n, load_n, en_n, busy_n, done_n, done_v, gnt_v, ldv_load, ldv_end, both_n, gnt_bad, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (gnt_v !== 2'b01) begin failures++; $display("FAIL basic_gnt got=%b exp=01", gnt_v); end
        checks++; if (idle_n !== 0) begin failures++; $display("FAIL basic_latency got=%0d exp=0", idle_n); end
        checks++; if (load_n !== 1) begin failures++; $display("FAIL basic_load_cycles got=%0d exp=1", load_n); end
        checks++; if (ldv_load !== 8'hC5) begin failures++; $display("FAIL basic_load_val got=%h exp=c5", ldv_load); end
        checks++; if (ldv_end !== 8'hC5) begin failures++; $display("FAIL basic_load_val_held got=%h exp=c5", ldv_end); end
        checks++; if (en_n !== 3) begin failures++; $display("FAIL basic_en_cycles got=%0d exp=3", en_n); end
        checks++; if (busy_n !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", busy_n); end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_n); end
        checks++; if (done_v !== 2'b01) begin failures++; $display("FAIL basic_done_owner got=%b exp=01", done_v); end
        checks++; if (both_n !== 0) begin failures++; $display("FAIL basic_load_en_overlap got=%0d exp=0", both_n); end
        checks++; if (gnt_bad !== 0) begin failures++; $display("FAIL basic_gnt_hold got=%0d exp=0", gnt_bad); end
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL basic_gnt_drop got=%b exp=00", gnt); end
    endtask

    task automatic test_zero_len();
        int idle_n, load_n, en_n, busy_n, done_n, both_n, gnt_bad;
        logic [1:0] done_v, gnt_v;
        logic [7:0] ldv_load, ldv_end;
        bit to;
        req = 2'b10; load_val_1 = 8'h5A; run_len_1 = 8'd0;
        run_job(0, idle_n, load_n, en_n, busy_n, done_n, done_v, gnt_v, ldv_load, ldv_end, both_n, gnt_bad, to);
        checks++; if (to) begin failures++; $display("FAIL zero_timeout got=1 exp=0"); end
        checks++; if (gnt_v !== 2'b10) begin failures++; $display("FAIL zero_gnt got=%b exp=10", gnt_v); end
        checks++; if (ldv_load !== 8'h5A) begin failures++; $display("FAIL zero_load_val got=%h exp=5a", ldv_load); end
        checks++; if (en_n !== 0) begin failures++; $display("FAIL zero_en_cycles got=%0d exp=0", en_n); end
        checks++; if (busy_n !== 2) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=2", busy_n); end
        checks++; if (done_v !== 2'b10 || done_n !== 1) begin
            failures++; $display("FAIL zero_done got=%b x%0d exp=10 x1", done_v, done_n);
        end
    endtask

    task automatic test_back_to_back();
        int idle_n, load_n, en_n, busy_n, done_n, both_n, gnt_bad;
        logic [1:0] done_v, gnt_v;
        logic [7:0] ldv_load, ldv_end;
        logic [1:0] exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
        int exp_en [3] = '{2, 1, 2};
        bit to;
        do_reset();
        load_val_0 = 8'h11; run_len_0 = 8'd2;
        load_val_1 = 8'h22; run_len_1 = 8'd1;
        req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            run_job(1, idle_n, load_n, en_n, busy_n, done_n, done_v, gnt_v, ldv_load, ldv_end, both_n, gnt_bad, to);
            checks++; if (to) begin failures++; $display("FAIL b2b_timeout job=%0d", j); end
            checks++; if (gnt_v !== exp_gnt[j]) begin
                failures++; $display("FAIL b2b_gnt job=%0d got=%b exp=%b", j, gnt_v, exp_gnt[j]);
            end
            checks++; if (idle_n !== 0) begin
                failures++; $display("FAIL b2b_idle_gap job=%0d got=%0d extra idle cycles exp=0", j, idle_n);
            end
            checks++; if (en_n !== exp_en[j] || done_v !== exp_gnt[j]) begin
                failures++; $display("FAIL b2b_job job=%0d en=%0d done=%b exp en=%0d done=%b",
                                     j, en_n, done_v, exp_en[j], exp_gnt[j]);
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_long();
        int idle_n, load_n, en_n, busy_n, done_n, both_n, gnt_bad;
        logic [1:0] done_v, gnt_v;
        logic [7:0] ldv_load, ldv_end;
        bit to;
        req = 2'b01; load_val_0 = 8'hFF; run_len_0 = 8'd255;
        run_job(0, idle_n, load_n, en_n, busy_n, done_n, done_v, gnt_v, ldv_load, ldv_end, both_n, gnt_bad, to);
        checks++; if (to) begin failures++; $display("FAIL long_timeout got=1 exp=0"); end
        checks++; if (en_n !== 255) begin failures++; $display("FAIL long_en_cycles got=%0d exp=255", en_n); end
        checks++; if (busy_n !== 257) begin failures++; $display("FAIL long_busy_cycles got=%0d exp=257", busy_n); end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL long_done_pulses got=%0d exp=1", done_n); end
    endtask

    task automatic test_reset_midjob();
        int idle_n, load_n, en_n, busy_n, done_n, both_n, gnt_bad;
        logic [1:0] done_v, gnt_v;
        logic [7:0] ldv_load, ldv_end;
        bit to;
        int dn = 0;
        req = 2'b01; load_val_0 = 8'h77; run_len_0 = 8'd5;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cnt_en !== 1'b1) begin failures++; $display("FAIL midrst_running got=%b exp=1", cnt_en); end
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, busy, cnt_load, cnt_en, cnt_load_val} !== 15'd0) begin
            failures++;
            $display("FAIL midrst_async got gnt=%b done=%b busy=%b en=%b val=%h required all zero",
                     gnt, done, busy, cnt_en, cnt_load_val);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 2'b00) dn++;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d pulses exp=0", dn); end
        req = 2'b11; load_val_0 = 8'h01; run_len_0 = 8'd1; load_val_1 = 8'h02; run_len_1 = 8'd1;
        run_job(0, idle_n, load_n, en_n, busy_n, done_n, done_v, gnt_v, ldv_load, ldv_end, both_n, gnt_bad, to);
        checks++; if (gnt_v !== 2'b01) begin failures++; $display("FAIL midrst_next_gnt got=%b exp=01", gnt_v); end
    endtask

`ifdef CNT_CTRL_ABORT_EN
    task automatic test_abort();
        int dn = 0;
        abort = 1'b1;
        req = 2'b01; load_val_0 = 8'h44; run_len_0 = 8'd10;
        @(negedge clk);
        checks++; if (cnt_load !== 1'b1) begin failures++; $display("FAIL abort_idle_ignored got=%b exp=1", cnt_load); end
        abort = 1'b0; req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cnt_en !== 1'b1) begin failures++; $display("FAIL abort_running got=%b exp=1", cnt_en); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL abort_en_low got=%b exp=0", cnt_en); end
        checks++; if (done !== 2'b01) begin failures++; $display("FAIL abort_done got=%b exp=01", done); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 2'b00) dn++;
        end
        checks++; if (dn !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle extra_done=%0d busy=%b exp 0 and 0", dn, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_back_to_back();
        test_long();
        test_reset_midjob();
`ifdef CNT_CTRL_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
